// File: rtl/adc_sample_reader_pkg.sv
// Shared definitions for the ADC sample reader: FSM encoding, default frame
// geometry and a counter-width helper.
package adc_sample_reader_pkg;

    localparam int DEFAULT_FRAME_BITS = 16;
    localparam int DEFAULT_ADC_BITS   = 12;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_CS_SETUP = 3'd1;
    localparam logic [2:0] ENC_SHIFT    = 3'd2;
    localparam logic [2:0] ENC_CS_HOLD  = 3'd3;
    localparam logic [2:0] ENC_LOAD     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ENC_IDLE,
        CS_SETUP = ENC_CS_SETUP,
        SHIFT    = ENC_SHIFT,
        CS_HOLD  = ENC_CS_HOLD,
        LOAD     = ENC_LOAD
    } state_t;

    // Bits needed for a counter that spans 0..num_values-1 (never below 1).
    function automatic int cnt_width(input int num_values);
        return (num_values <= 2) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/adc_sample_reader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/adc_sample_reader.sv
// SPI master for an AD7476-style 12-bit ADC: periodic conversions, signed
// sample output and a stretched sample strobe for the servo controller.
module adc_sample_reader
    import adc_sample_reader_pkg::*;
#(
    parameter int N             = 18,
    parameter int ADC_BITS      = DEFAULT_ADC_BITS,
    parameter int FRAME_BITS    = DEFAULT_FRAME_BITS,
    parameter int SCLK_DIV      = 4,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int STROBE_LEN    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                adc_sdata,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic signed [N-1:0] y,
    output logic                enable,
    output logic                frame_err
);

    localparam int TIMER_W  = cnt_width(SAMPLE_PERIOD);
    localparam int PHASE_W  = cnt_width(SCLK_DIV);
    localparam int BIT_W    = cnt_width(FRAME_BITS);
    localparam int STROBE_W = cnt_width(STROBE_LEN + 1);

    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [PHASE_W-1:0]  PHASE_LAST  = PHASE_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(FRAME_BITS - 1);
    localparam logic [STROBE_W-1:0] STROBE_INIT = STROBE_W'(STROBE_LEN);

    state_t                  state_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic [PHASE_W-1:0]      phase_reg;
    logic [BIT_W-1:0]        bit_reg;
    logic                    sclk_high_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    cs_n_reg;
    logic                    sclk_reg;
    logic signed [N-1:0]     y_reg;
    logic                    frame_err_reg;
    logic [STROBE_W-1:0]     strobe_reg;
    logic                    sdata_s;
    logic                    tick;
    logic                    lead_ok;

    sync_2ff #(.RESET_VALUE(1'b0)) u_sdata_sync (
        .clk   (clk),
        .reset (reset),
        .d     (adc_sdata),
        .q     (sdata_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (!run || timer_reg == TIMER_LAST) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign tick    = run && (timer_reg == TIMER_LAST);
    assign lead_ok = (shift_reg[FRAME_BITS-1:ADC_BITS] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            bit_reg       <= '0;
            sclk_high_reg <= 1'b0;
            shift_reg     <= '0;
            cs_n_reg      <= 1'b1;
            sclk_reg      <= 1'b1;
            y_reg         <= '0;
            frame_err_reg <= 1'b0;
            strobe_reg    <= '0;
        end else begin
            frame_err_reg <= 1'b0;
            if (strobe_reg != '0) begin
                strobe_reg <= strobe_reg - 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    // Ticks are only honoured here; one arriving mid-frame is lost.
                    if (tick) begin
                        state_reg <= CS_SETUP;
                        cs_n_reg  <= 1'b0;
                        phase_reg <= '0;
                    end
                end
                CS_SETUP: begin
                    if (phase_reg == PHASE_LAST) begin
                        state_reg     <= SHIFT;
                        phase_reg     <= '0;
                        bit_reg       <= '0;
                        sclk_high_reg <= 1'b0;
                        sclk_reg      <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (phase_reg == PHASE_LAST) begin
                        phase_reg <= '0;
                        if (!sclk_high_reg) begin
                            sclk_high_reg <= 1'b1;
                            sclk_reg      <= 1'b1;
                        end else begin
                            // Sample at the end of the high phase, furthest from the data change.
                            sclk_high_reg <= 1'b0;
                            shift_reg     <= {shift_reg[FRAME_BITS-2:0], sdata_s};
                            if (bit_reg == BIT_LAST) begin
                                state_reg <= CS_HOLD;
                            end else begin
                                bit_reg  <= bit_reg + 1'b1;
                                sclk_reg <= 1'b0;
                            end
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (phase_reg == PHASE_LAST) begin
                        state_reg <= LOAD;
                        cs_n_reg  <= 1'b1;
                        phase_reg <= '0;
                        // y settles during LOAD so it leads the strobe by one cycle.
                        if (lead_ok) begin
                            y_reg <= {{(N-ADC_BITS){1'b0}}, shift_reg[ADC_BITS-1:0]};
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                LOAD: begin
                    if (lead_ok) begin
                        strobe_reg <= STROBE_INIT;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    cs_n_reg  <= 1'b1;
                    sclk_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign adc_cs_n  = cs_n_reg;
    assign adc_sclk  = sclk_reg;
    assign y         = y_reg;
    assign enable    = (strobe_reg != '0);
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Self-checking bench: ADC serial model, timeline-based reference model compared
// every cycle, plus directed literal checks on frame, reset and run behaviour.
module tb_adc_sample_reader;

    localparam int N         = 18;
    localparam int SD        = 4;
    localparam int SP        = 150;
    localparam int SL        = 4;
    localparam int FRAME_CYC = 34 * SD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic adc_sdata = 1'b0;
    logic adc_cs_n;
    logic adc_sclk;
    logic signed [N-1:0] y;
    logic enable;
    logic frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    adc_sample_reader #(
        .N(N), .ADC_BITS(12), .FRAME_BITS(16), .SCLK_DIV(SD),
        .SAMPLE_PERIOD(SP), .STROBE_LEN(SL)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .adc_sdata(adc_sdata),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .y(y),
        .enable(enable), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] words [0:7] = '{16'h0FFF, 16'h0000, 16'h0ABC, 16'h8123,
                                 16'h0555, 16'h0321, 16'h0777, 16'h0000};

    function automatic logic [15:0] get_word(input int i);
        return (i < 8) ? words[i] : 16'h0000;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC: new frame word on CS fall, next bit (MSB first) on each SCLK fall.
    int adc_idx = 0;
    int adc_bit = -1;
    logic [15:0] adc_word = 16'h0000;
    always @(negedge adc_cs_n) begin
        adc_word = get_word(adc_idx);
        adc_idx++;
        adc_bit = 15;
    end
    always @(negedge adc_sclk) begin
        if (adc_cs_n == 1'b0 && adc_bit >= 0) begin
            adc_sdata = adc_word[adc_bit];
            adc_bit--;
        end
    end

    // Reference model: frame timeline as an offset o from the first CS-low cycle.
    int tm = 0;
    int o = 0;
    bit in_frame = 0;
    int m_idx = 0;
    logic [15:0] m_word = 16'h0000;
    longint y_exp = 0;
    int en_left = 0;
    bit m_tick, exp_cs_n, exp_sclk, exp_err;

    always @(negedge clk) begin
        if (reset) begin
            tm = 0; in_frame = 0; y_exp = 0; en_left = 0;
        end
        exp_cs_n = !(in_frame && o < FRAME_CYC);
        exp_sclk = !(in_frame && o >= SD && o < 33 * SD && ((o - SD) / SD) % 2 == 0);
        exp_err  = in_frame && o == FRAME_CYC && m_word[15:12] != 4'h0;
        check("cmp_cs_n", adc_cs_n, exp_cs_n);
        check("cmp_sclk", adc_sclk, exp_sclk);
        check("cmp_y", y, y_exp);
        check("cmp_enable", enable, en_left != 0);
        check("cmp_frame_err", frame_err, exp_err);
        if (!reset) begin
            m_tick = run && tm == SP - 1;
            tm = (run && tm != SP - 1) ? tm + 1 : 0;
            if (en_left > 0) en_left--;
            if (in_frame) begin
                if (o == FRAME_CYC - 1 && m_word[15:12] == 4'h0) y_exp = m_word[11:0];
                if (o == FRAME_CYC) begin
                    in_frame = 0;
                    if (m_word[15:12] == 4'h0) en_left = SL;
                end else begin
                    o++;
                end
            end else if (m_tick) begin
                in_frame = 1; o = 0;
                m_word = get_word(m_idx);
                m_idx++;
            end
        end
    end

    // Event recorder for the directed literal checks.
    int cs_fall_cyc[$];
    int falls_per_frame[$];
    int rise_y[$];
    int en_len[$];
    int en_gap[$];
    int sclk_falls = 0, err_pulses = 0, sclk_idle_edges = 0;
    int en_run = 0, low_run = 0, cs_high_run = 0, min_cs_high = 1000000;
    bit seen_strobe = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_en = 1'b0;
    logic [N-1:0] y_prev = '0;

    always @(negedge clk) begin
        if (reset) begin
            sclk_falls = 0;
        end else begin
            if (prev_cs && !adc_cs_n) begin
                cs_fall_cyc.push_back(cyc);
                if (cs_high_run < min_cs_high) min_cs_high = cs_high_run;
                cs_high_run = 0;
                sclk_falls = 0;
            end
            if (adc_cs_n) cs_high_run++;
            if (!adc_cs_n && prev_sclk && !adc_sclk) sclk_falls++;
            if (adc_cs_n && !prev_cs) falls_per_frame.push_back(sclk_falls);
            if (adc_cs_n && prev_cs && adc_sclk != prev_sclk) sclk_idle_edges++;
            if (frame_err) err_pulses++;
            if (!prev_en && enable) begin
                rise_y.push_back(int'(y_prev));
                if (seen_strobe) en_gap.push_back(low_run);
                seen_strobe = 1;
                en_run = 0;
            end
            if (prev_en && !enable) begin
                en_len.push_back(en_run);
                low_run = 0;
            end
            if (enable) en_run++; else low_run++;
        end
        prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_en = enable; y_prev = y;
    end

    task automatic wait_cs_falls(input int n, input int limit);
        int k = 0;
        while (cs_fall_cyc.size() < n && k < limit) begin
            @(posedge clk); #2;
            k++;
        end
        if (cs_fall_cyc.size() < n) check("wait_cs_fall_timeout", cs_fall_cyc.size(), n);
    endtask

    int rel;

    initial begin
        reset = 1'b1; run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n", adc_cs_n, 1);
        check("reset_sclk", adc_sclk, 1);
        check("reset_y", y, 0);
        check("reset_enable", enable, 0);
        check("reset_frame_err", frame_err, 0);

        @(posedge clk); #1;
        reset = 1'b0; run = 1'b1;
        rel = cyc;
        wait_cs_falls(5, 5 * SP + 50);
        check("first_tick_delay", cs_fall_cyc[0] - rel, SP);
        for (int i = 1; i < 5; i++) check("cs_fall_spacing", cs_fall_cyc[i] - cs_fall_cyc[i-1], SP);
        for (int i = 0; i < 4; i++) check("sclk_falls_per_frame", falls_per_frame[i], 16);
        check("strobe_count_a", rise_y.size(), 3);
        check("y_before_rise_0fff", rise_y[0], 4095);
        check("y_before_rise_0000", rise_y[1], 0);
        check("y_before_rise_0abc", rise_y[2], 2748);
        for (int i = 0; i < 3; i++) check("enable_len", en_len[i], SL);
        check("frame_err_pulses", err_pulses, 1);
        check("y_held_after_bad_frame", y, 2748);
        check("enable_gap_0", en_gap[0], SP - SL);
        check("enable_gap_1", en_gap[1], SP - SL);
        check("cs_high_between_frames", min_cs_high, SP - FRAME_CYC);

        // Abort frame 4 in the low phase of bit 7.
        repeat (SD + 14 * SD - 1) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midframe_reset_cs_n", adc_cs_n, 1);
        check("midframe_reset_sclk", adc_sclk, 1);
        check("midframe_reset_y", y, 0);
        check("midframe_reset_enable", enable, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        rel = cyc;
        wait_cs_falls(6, SP + 20);
        check("tick_after_reset", cs_fall_cyc[5] - rel, SP);

        // Drop run during bit 3 of frame 6.
        wait_cs_falls(7, SP + 20);
        check("cs_fall_spacing_6", cs_fall_cyc[6] - cs_fall_cyc[5], SP);
        repeat (SD + 6 * SD) @(posedge clk);
        #1 run = 1'b0;
        repeat (FRAME_CYC + 10) @(posedge clk);
        #1;
        check("strobe_count_b", rise_y.size(), 5);
        check("y_before_rise_0321", rise_y[3], 801);
        check("y_before_rise_0777", rise_y[4], 1911);
        check("enable_len_run_drop", en_len[4], SL);
        check("y_after_run_drop", y, 1911);
        check("sclk_falls_frame6", falls_per_frame[5], 16);
        repeat (3 * SP) @(posedge clk);
        #1;
        check("no_cs_fall_after_run_drop", cs_fall_cyc.size(), 7);
        check("sclk_edges_while_idle", sclk_idle_edges, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
